mult_hilo_unit: RTL

Multi-cycle unsigned multiplier with the architectural HI/LO register pair for the MIPS datapath. It sits directly downstream of the ALU auxiliary decoder and consumes its we_hilo (start multiply), hilo_sel (HI/LO read select) and alu_out_sel (HI/LO read request) controls. It replaces a combinational multiply with a radix-2 shift-add engine. It raises a stall to the PC/pipeline control while a result is pending.

---
 rtl/mult_hilo_unit.sv | 103 ++++++++++
 1 files changed

// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit: radix-2 shift-add multiplier with MIPS HI/LO registers; optional signed mode via MULT_SIGNED_EN
module mult_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             read_req,
    input  logic             hilo_sel,
`ifdef MULT_SIGNED_EN
    input  logic             is_signed,
`endif
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hilo_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    state_t                 r_state, w_next;
    logic [WIDTH-1:0]       r_a, r_b, r_hi, r_lo, w_a_in, w_b_in;
    logic [2*WIDTH-1:0]     r_acc, w_acc_nx, w_result;
    logic [CNT_W-1:0]       r_cnt;
    logic [WIDTH:0]         w_sum;
    logic                   w_accept, w_last;
`ifdef MULT_SIGNED_EN
    logic                   r_neg, w_neg_in;
    assign w_a_in   = (is_signed & op_a[WIDTH-1]) ? -op_a : op_a;
    assign w_b_in   = (is_signed & op_b[WIDTH-1]) ? -op_b : op_b;
    assign w_neg_in = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
    assign w_result = r_neg ? -w_acc_nx : w_acc_nx;
`else
    assign w_a_in   = op_a;
    assign w_b_in   = op_b;
    assign w_result = w_acc_nx;
`endif
    assign w_accept = start & (r_state != S_BUSY);
    assign w_last   = r_cnt == CNT_W'(WIDTH - 1);
    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_acc_nx = {w_sum, r_acc[WIDTH-1:1]};
    assign busy     = r_state == S_BUSY;
    assign done     = r_state == S_DONE;
    assign stall    = busy & (read_req | start);
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign hilo_out = hilo_sel ? r_lo : r_hi;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next state: start is honoured from IDLE and DONE, never from BUSY
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = start ? S_BUSY : S_IDLE;
            S_BUSY:  w_next = w_last ? S_DONE : S_BUSY;
            S_DONE:  w_next = start ? S_BUSY : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // operand latch and one shift-add iteration per busy cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
`ifdef MULT_SIGNED_EN
            r_neg <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a   <= w_a_in;
            r_b   <= w_b_in;
            r_acc <= '0;
            r_cnt <= '0;
`ifdef MULT_SIGNED_EN
            r_neg <= w_neg_in;
`endif
        end else if (busy) begin
            r_acc <= w_acc_nx;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // HI/LO change only on the final iteration so readers never see partial products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (busy && w_last) begin
            {r_hi, r_lo} <= w_result;
        end
    end
endmodule
